// File: rtl/usb_tx_arbiter.sv
// Packet-level AXI-stream arbiter merging command responses (s0) and ADC samples (s1)
// onto the single USB bridge path. Define USB_TX_ARB_STATS_EN to add packet/stall counters.
module usb_tx_arbiter #(
  parameter int unsigned ROUND_ROBIN = 1,
  parameter int unsigned S1_MAX_PKTS = 0
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        s0_tready,
  input  logic        s0_tvalid,
  input  logic [31:0] s0_tdata,
  input  logic [3:0]  s0_tkeep,
  input  logic        s0_tlast,
  output logic        s1_tready,
  input  logic        s1_tvalid,
  input  logic [31:0] s1_tdata,
  input  logic [3:0]  s1_tkeep,
  input  logic        s1_tlast,
  input  logic        m_tready,
  output logic        m_tvalid,
  output logic [31:0] m_tdata,
  output logic [3:0]  m_tkeep,
  output logic        m_tlast,
`ifdef USB_TX_ARB_STATS_EN
  input  logic        stats_clr,
  output logic [15:0] pkt_cnt0,
  output logic [15:0] pkt_cnt1,
  output logic [15:0] stall_cnt,
`endif
  output logic [1:0]  grant,
  output logic        busy
);

  localparam int unsigned CNT_W = 8;

  // One-hot encoding so the grant output is the state register itself.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;      // 1 = s1 owned the previous packet
  logic [CNT_W-1:0] s1_cnt_q, s1_cnt_d;
  logic             done0_c, done1_c;
  logic             s1_capped_c, s1_eligible_c;

  assign done0_c = (state_q == GRANT0) && s0_tvalid && m_tready && s0_tlast;
  assign done1_c = (state_q == GRANT1) && s1_tvalid && m_tready && s1_tlast;

  // After S1_MAX_PKTS back-to-back s1 packets, a waiting s0 must win the next grant.
  assign s1_capped_c   = (ROUND_ROBIN == 0) && (S1_MAX_PKTS != 0) &&
                         (32'(s1_cnt_q) >= S1_MAX_PKTS);
  assign s1_eligible_c = s1_tvalid && !(s1_capped_c && s0_tvalid);

  assign grant = state_q;
  assign busy  = (state_q != IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      s1_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      s1_cnt_q <= s1_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    s1_cnt_d  = s1_cnt_q;
    m_tvalid  = 1'b0;
    m_tdata   = '0;
    m_tkeep   = '0;
    m_tlast   = 1'b0;
    s0_tready = 1'b0;
    s1_tready = 1'b0;
    case (state_q)
      IDLE: begin
        if (s0_tvalid && s1_eligible_c && (ROUND_ROBIN != 0)) begin
          state_d = last_q ? GRANT0 : GRANT1;
        end else if (s0_tvalid) begin
          state_d = GRANT0;
        end else if (s1_eligible_c) begin
          state_d = GRANT1;
        end
      end
      GRANT0: begin
        m_tvalid  = s0_tvalid;
        m_tdata   = s0_tdata;
        m_tkeep   = s0_tkeep;
        m_tlast   = s0_tlast;
        s0_tready = m_tready;
        if (done0_c) begin
          state_d  = IDLE;
          last_d   = 1'b0;
          s1_cnt_d = '0;
        end
      end
      GRANT1: begin
        m_tvalid  = s1_tvalid;
        m_tdata   = s1_tdata;
        m_tkeep   = s1_tkeep;
        m_tlast   = s1_tlast;
        s1_tready = m_tready;
        if (done1_c) begin
          state_d = IDLE;
          last_d  = 1'b1;
          if (s1_cnt_q != '1) begin
            s1_cnt_d = s1_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef USB_TX_ARB_STATS_EN
  localparam int unsigned STAT_W = 16;

  logic [STAT_W-1:0] pkt_cnt0_q, pkt_cnt1_q, stall_cnt_q;
  logic              stall_c;

  assign stall_c = m_tvalid && !m_tready;

  // Packet counters wrap; stall counter saturates; clear beats any increment.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pkt_cnt0_q  <= '0;
      pkt_cnt1_q  <= '0;
      stall_cnt_q <= '0;
    end else if (stats_clr) begin
      pkt_cnt0_q  <= '0;
      pkt_cnt1_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (done0_c) begin
        pkt_cnt0_q <= pkt_cnt0_q + STAT_W'(1);
      end
      if (done1_c) begin
        pkt_cnt1_q <= pkt_cnt1_q + STAT_W'(1);
      end
      if (stall_c && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + STAT_W'(1);
      end
    end
  end

  assign pkt_cnt0  = pkt_cnt0_q;
  assign pkt_cnt1  = pkt_cnt1_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Self-checking bench for usb_tx_arbiter: directed scenarios plus randomized traffic
// checked cycle-by-cycle against an owner-tracking reference model.
module tb_usb_tx_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        s0_tready, s0_tvalid, s0_tlast;
  logic [31:0] s0_tdata;
  logic [3:0]  s0_tkeep;
  logic        s1_tready, s1_tvalid, s1_tlast;
  logic [31:0] s1_tdata;
  logic [3:0]  s1_tkeep;
  logic        m_tready, m_tvalid, m_tlast;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic [1:0]  grant;
  logic        busy;

  logic        f_s0_tready, f_s0_tvalid, f_s0_tlast;
  logic [31:0] f_s0_tdata;
  logic [3:0]  f_s0_tkeep;
  logic        f_s1_tready, f_s1_tvalid, f_s1_tlast;
  logic [31:0] f_s1_tdata;
  logic [3:0]  f_s1_tkeep;
  logic        f_m_tready, f_m_tvalid, f_m_tlast;
  logic [31:0] f_m_tdata;
  logic [3:0]  f_m_tkeep;
  logic [1:0]  f_grant;
  logic        f_busy;

`ifdef USB_TX_ARB_STATS_EN
  logic        stats_clr, f_stats_clr;
  logic [15:0] pkt_cnt0, pkt_cnt1, stall_cnt;
  logic [15:0] f_pkt_cnt0, f_pkt_cnt1, f_stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  usb_tx_arbiter #(.ROUND_ROBIN(1), .S1_MAX_PKTS(0)) dut (
    .clk(clk), .rstn(rstn),
    .s0_tready(s0_tready), .s0_tvalid(s0_tvalid), .s0_tdata(s0_tdata),
    .s0_tkeep(s0_tkeep), .s0_tlast(s0_tlast),
    .s1_tready(s1_tready), .s1_tvalid(s1_tvalid), .s1_tdata(s1_tdata),
    .s1_tkeep(s1_tkeep), .s1_tlast(s1_tlast),
    .m_tready(m_tready), .m_tvalid(m_tvalid), .m_tdata(m_tdata),
    .m_tkeep(m_tkeep), .m_tlast(m_tlast),
`ifdef USB_TX_ARB_STATS_EN
    .stats_clr(stats_clr), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .stall_cnt(stall_cnt),
`endif
    .grant(grant), .busy(busy)
  );

  usb_tx_arbiter #(.ROUND_ROBIN(0), .S1_MAX_PKTS(2)) dut_fp (
    .clk(clk), .rstn(rstn),
    .s0_tready(f_s0_tready), .s0_tvalid(f_s0_tvalid), .s0_tdata(f_s0_tdata),
    .s0_tkeep(f_s0_tkeep), .s0_tlast(f_s0_tlast),
    .s1_tready(f_s1_tready), .s1_tvalid(f_s1_tvalid), .s1_tdata(f_s1_tdata),
    .s1_tkeep(f_s1_tkeep), .s1_tlast(f_s1_tlast),
    .m_tready(f_m_tready), .m_tvalid(f_m_tvalid), .m_tdata(f_m_tdata),
    .m_tkeep(f_m_tkeep), .m_tlast(f_m_tlast),
`ifdef USB_TX_ARB_STATS_EN
    .stats_clr(f_stats_clr), .pkt_cnt0(f_pkt_cnt0), .pkt_cnt1(f_pkt_cnt1),
    .stall_cnt(f_stall_cnt),
`endif
    .grant(f_grant), .busy(f_busy)
  );

  task automatic idle_inputs;
    s0_tvalid = 1'b0; s0_tdata = '0; s0_tkeep = '0; s0_tlast = 1'b0;
    s1_tvalid = 1'b0; s1_tdata = '0; s1_tkeep = '0; s1_tlast = 1'b0;
    m_tready  = 1'b0;
    f_s0_tvalid = 1'b0; f_s0_tdata = '0; f_s0_tkeep = '0; f_s0_tlast = 1'b0;
    f_s1_tvalid = 1'b0; f_s1_tdata = '0; f_s1_tkeep = '0; f_s1_tlast = 1'b0;
    f_m_tready  = 1'b0;
`ifdef USB_TX_ARB_STATS_EN
    stats_clr = 1'b0; f_stats_clr = 1'b0;
`endif
  endtask

  task automatic do_reset;
    @(negedge clk);
    rstn = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset;
    logic [42:0] act;
    rstn = 1'b0;
    idle_inputs();
    #1;
    act = {m_tvalid, m_tdata, m_tkeep, m_tlast, s0_tready, s1_tready, grant, busy};
    n_cmp++;
    if (act !== 43'd0) begin
      n_err++; $display("FAIL reset_outputs: got %h want 0", act);
    end
    @(negedge clk); rstn = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    act = {m_tvalid, m_tdata, m_tkeep, m_tlast, s0_tready, s1_tready, grant, busy};
    n_cmp++;
    if (act !== 43'd0) begin
      n_err++; $display("FAIL reset_idle_hold: got %h want 0", act);
    end
`ifdef USB_TX_ARB_STATS_EN
    n_cmp++;
    if ({pkt_cnt0, pkt_cnt1, stall_cnt} !== 48'd0) begin
      n_err++; $display("FAIL reset_stats: got %h want 0", {pkt_cnt0, pkt_cnt1, stall_cnt});
    end
`endif
  endtask

  task automatic test_s0_basic;
    logic [42:0] act, exp;
    do_reset();
    @(negedge clk);
    m_tready = 1'b1; s0_tvalid = 1'b1; s0_tdata = 32'hAABBCCDD; s0_tkeep = 4'hF; s0_tlast = 1'b0;
    #1;
    n_cmp++;
    if ({grant, m_tvalid} !== 3'b000) begin
      n_err++; $display("FAIL s0_first_idle: got grant=%b m_tvalid=%b want 00/0", grant, m_tvalid);
    end
    @(negedge clk); #1;
    act = {m_tvalid, m_tdata, m_tkeep, m_tlast, s0_tready, s1_tready, grant, busy};
    exp = {1'b1, 32'hAABBCCDD, 4'hF, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1};
    n_cmp++;
    if (act !== exp) begin
      n_err++; $display("FAIL s0_beat0: got %h want %h", act, exp);
    end
    @(negedge clk);
    s0_tdata = 32'h11223344; s0_tkeep = 4'b0011; s0_tlast = 1'b1;
    #1;
    act = {m_tvalid, m_tdata, m_tkeep, m_tlast, s0_tready, s1_tready, grant, busy};
    exp = {1'b1, 32'h11223344, 4'b0011, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1};
    n_cmp++;
    if (act !== exp) begin
      n_err++; $display("FAIL s0_beat1: got %h want %h", act, exp);
    end
    @(negedge clk);
    s0_tvalid = 1'b0;
    #1;
    act = {m_tvalid, m_tdata, m_tkeep, m_tlast, s0_tready, s1_tready, grant, busy};
    n_cmp++;
    if (act !== 43'd0) begin
      n_err++; $display("FAIL s0_return_idle: got %h want 0", act);
    end
  endtask

  task automatic test_zero_len;
    logic [42:0] act, exp;
    do_reset();
    @(negedge clk);
    m_tready = 1'b1; s0_tvalid = 1'b1; s0_tdata = 32'h5A5A0000; s0_tkeep = 4'h0; s0_tlast = 1'b1;
    @(negedge clk); #1;
    act = {m_tvalid, m_tdata, m_tkeep, m_tlast, s0_tready, s1_tready, grant, busy};
    exp = {1'b1, 32'h5A5A0000, 4'h0, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1};
    n_cmp++;
    if (act !== exp) begin
      n_err++; $display("FAIL zlp_forward: got %h want %h", act, exp);
    end
    @(negedge clk);
    s0_tvalid = 1'b0;
    #1;
    n_cmp++;
    if ({grant, busy, m_tvalid} !== 4'b0000) begin
      n_err++; $display("FAIL zlp_idle: got grant=%b busy=%b m_tvalid=%b want 0", grant, busy, m_tvalid);
    end
  endtask

  task automatic test_round_robin;
    int b0, b1, k, pos;
    logic [37:0] act, exp;
    logic [31:0] d;
    do_reset();
    b0 = 0; b1 = 0;
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      m_tready  = 1'b1;
      s0_tvalid = 1'b1; s0_tdata = 32'hA000_0000 + 32'(b0); s0_tkeep = 4'hF; s0_tlast = (b0 % 3 == 2);
      s1_tvalid = 1'b1; s1_tdata = 32'hB000_0000 + 32'(b1); s1_tkeep = 4'hF; s1_tlast = (b1 % 3 == 2);
      #1;
      // 4-cycle period: one bubble then three beats, owners alternate starting with s0
      k = c / 4; pos = c % 4;
      if (pos == 0) begin
        exp = '0;
      end else begin
        d = ((k % 2 == 0) ? 32'hA000_0000 : 32'hB000_0000) + 32'((k / 2) * 3 + pos - 1);
        exp = {(k % 2 == 0) ? 2'b01 : 2'b10, 1'b1, d, (pos == 3), (k % 2 == 0), (k % 2 == 1)};
      end
      act = {grant, m_tvalid, m_tdata, m_tlast, s0_tready, s1_tready};
      n_cmp++;
      if (act !== exp) begin
        n_err++; $display("FAIL rr_cycle%0d: got %h want %h", c, act, exp);
      end
      if (s0_tvalid && s0_tready) b0++;
      if (s1_tvalid && s1_tready) b1++;
    end
  endtask

  task automatic test_stalls;
    logic [7:0]  mr_pat, vd_pat;
    logic [40:0] act, exp;
    int beat, ndel;
    logic done;
    mr_pat = 8'b1111_1001;
    vd_pat = 8'b1100_1111;
    do_reset();
    @(negedge clk);
    m_tready = 1'b1; s1_tvalid = 1'b1; s1_tdata = 32'hC0DE0000; s1_tkeep = 4'hF; s1_tlast = 1'b0;
    beat = 0; ndel = 0; done = 1'b0;
    for (int c = 0; c < 16 && !done; c++) begin
      @(negedge clk);
      m_tready  = (c < 8) ? mr_pat[c] : 1'b1;
      s1_tvalid = (c < 8) ? vd_pat[c] : 1'b1;
      s1_tdata  = 32'hC0DE0000 + 32'(beat);
      s1_tlast  = (beat == 3);
      #1;
      act = {grant, busy, s0_tready, s1_tready, m_tvalid, m_tdata, m_tlast};
      exp = {2'b10, 1'b1, 1'b0, m_tready, s1_tvalid, s1_tdata, s1_tlast};
      n_cmp++;
      if (act !== exp) begin
        n_err++; $display("FAIL stall_cycle%0d: got %h want %h", c, act, exp);
      end
      if (m_tvalid && m_tready) begin
        n_cmp++;
        if (m_tdata !== 32'hC0DE0000 + 32'(ndel)) begin
          n_err++; $display("FAIL stall_order: got %h want %h", m_tdata, 32'hC0DE0000 + 32'(ndel));
        end
        ndel++;
        if (m_tlast) done = 1'b1;
        beat++;
      end
    end
    n_cmp++;
    if (ndel != 4) begin
      n_err++; $display("FAIL stall_delivered: got %0d beats want 4", ndel);
    end
    @(negedge clk);
    s1_tvalid = 1'b0;
    #1;
    n_cmp++;
    if ({grant, busy} !== 3'b000) begin
      n_err++; $display("FAIL stall_idle: got grant=%b busy=%b want 00/0", grant, busy);
    end
  endtask

  task automatic test_fixed_prio;
    int n1;
    logic seen_idle, done;
    logic [43:0] act, exp;
    do_reset();
    n1 = 0; seen_idle = 1'b0; done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      f_m_tready  = 1'b1;
      f_s1_tvalid = 1'b1; f_s1_tdata = 32'hE000_0000 + 32'(n1); f_s1_tkeep = 4'hF; f_s1_tlast = 1'b1;
      f_s0_tvalid = (n1 >= 2); f_s0_tdata = 32'hD0DE0001; f_s0_tkeep = 4'hF; f_s0_tlast = 1'b1;
      #1;
      if (f_grant != 2'b00 && seen_idle) begin
        act = {f_grant, f_busy, f_s0_tready, f_s1_tready, f_m_tvalid, f_m_tdata, f_m_tkeep, f_m_tlast};
        exp = {2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 32'hD0DE0001, 4'hF, 1'b1};
        n_cmp++;
        if (act !== exp) begin
          n_err++; $display("FAIL fp_s0_wins: got %h want %h", act, exp);
        end
        done = 1'b1;
      end else if (f_grant != 2'b00) begin
        n_cmp++;
        if (f_grant !== 2'b10) begin
          n_err++; $display("FAIL fp_s1_grant: got %b want 10", f_grant);
        end
        if (f_m_tvalid && f_m_tready && f_m_tlast) n1++;
      end else if (f_s0_tvalid) begin
        seen_idle = 1'b1;
      end
    end
    n_cmp++;
    if (!done) begin
      n_err++; $display("FAIL fp_timeout: got no s0 grant want one within 20 cycles");
    end
    @(negedge clk);
    f_s0_tvalid = 1'b0; f_s1_tvalid = 1'b0;
    #1;
    n_cmp++;
    if (f_grant !== 2'b00) begin
      n_err++; $display("FAIL fp_idle: got %b want 00", f_grant);
    end
`ifdef USB_TX_ARB_STATS_EN
    n_cmp++;
    if ({f_pkt_cnt0, f_pkt_cnt1} !== {16'd1, 16'(n1)}) begin
      n_err++; $display("FAIL fp_stats: got %h want %h", {f_pkt_cnt0, f_pkt_cnt1}, {16'd1, 16'(n1)});
    end
`endif
  endtask

  task automatic test_random(input int cycles);
    int own, lastg, left0, left1, pk0, pk1, stalls;
    logic hold0, hold1, cur_v, cur_l;
    logic [42:0] act, exp;
    do_reset();
    own = -1; lastg = 1; left0 = 0; left1 = 0; pk0 = 0; pk1 = 0; stalls = 0;
    hold0 = 1'b0; hold1 = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (!hold0) begin
        if ($urandom_range(99) < 55) begin
          if (left0 == 0) left0 = $urandom_range(4, 1);
          s0_tvalid = 1'b1; s0_tlast = (left0 == 1);
        end else begin
          s0_tvalid = 1'b0; s0_tlast = 1'($urandom);
        end
        s0_tdata = $urandom; s0_tkeep = 4'($urandom);
      end
      if (!hold1) begin
        if ($urandom_range(99) < 55) begin
          if (left1 == 0) left1 = $urandom_range(4, 1);
          s1_tvalid = 1'b1; s1_tlast = (left1 == 1);
        end else begin
          s1_tvalid = 1'b0; s1_tlast = 1'($urandom);
        end
        s1_tdata = $urandom; s1_tkeep = 4'($urandom);
      end
      m_tready = ($urandom_range(99) < 70);
      #1;
      if (own == 0)
        exp = {s0_tvalid, s0_tdata, s0_tkeep, s0_tlast, m_tready, 1'b0, 2'b01, 1'b1};
      else if (own == 1)
        exp = {s1_tvalid, s1_tdata, s1_tkeep, s1_tlast, 1'b0, m_tready, 2'b10, 1'b1};
      else
        exp = '0;
      act = {m_tvalid, m_tdata, m_tkeep, m_tlast, s0_tready, s1_tready, grant, busy};
      n_cmp++;
      if (act !== exp) begin
        n_err++; $display("FAIL rand_cycle%0d: got %h want %h (owner %0d)", c, act, exp, own);
      end
      if (s0_tvalid && s0_tready) begin left0--; hold0 = 1'b0; end else hold0 = s0_tvalid;
      if (s1_tvalid && s1_tready) begin left1--; hold1 = 1'b0; end else hold1 = s1_tvalid;
      // Reference: owner keeps the path until its last beat is accepted
      if (own < 0) begin
        if (s0_tvalid && s1_tvalid) own = (lastg == 1) ? 0 : 1;
        else if (s0_tvalid) own = 0;
        else if (s1_tvalid) own = 1;
      end else begin
        cur_v = (own == 0) ? s0_tvalid : s1_tvalid;
        cur_l = (own == 0) ? s0_tlast  : s1_tlast;
        if (cur_v && !m_tready) stalls++;
        if (cur_v && m_tready && cur_l) begin
          if (own == 0) pk0++; else pk1++;
          lastg = own;
          own = -1;
        end
      end
    end
    @(negedge clk); #1;
    n_cmp++;
    if (pk0 == 0 || pk1 == 0) begin
      n_err++; $display("FAIL rand_traffic: got pk0=%0d pk1=%0d want both nonzero", pk0, pk1);
    end
`ifdef USB_TX_ARB_STATS_EN
    n_cmp++;
    if ({pkt_cnt0, pkt_cnt1, stall_cnt} !== {16'(pk0), 16'(pk1), 16'(stalls)}) begin
      n_err++; $display("FAIL rand_stats: got %h want %h", {pkt_cnt0, pkt_cnt1, stall_cnt},
                        {16'(pk0), 16'(pk1), 16'(stalls)});
    end
`endif
  endtask

`ifdef USB_TX_ARB_STATS_EN
  task automatic test_stats_clr;
    do_reset();
    @(negedge clk);
    s0_tvalid = 1'b1; s0_tdata = 32'h0BAD0001; s0_tkeep = 4'hF; s0_tlast = 1'b1; m_tready = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    n_cmp++;
    if (stall_cnt !== 16'd1) begin
      n_err++; $display("FAIL clr_stall_inc: got %0d want 1", stall_cnt);
    end
    stats_clr = 1'b1;
    @(negedge clk);
    m_tready = 1'b1;
    #1;
    n_cmp++;
    if (stall_cnt !== 16'd0) begin
      n_err++; $display("FAIL clr_over_stall: got %0d want 0", stall_cnt);
    end
    @(negedge clk);
    stats_clr = 1'b0; s0_tvalid = 1'b0;
    #1;
    n_cmp++;
    if ({pkt_cnt0, pkt_cnt1, stall_cnt, grant} !== 50'd0) begin
      n_err++; $display("FAIL clr_over_pkt: got %h want 0", {pkt_cnt0, pkt_cnt1, stall_cnt, grant});
    end
  endtask
`endif

  task automatic test_reset_mid;
    logic [42:0] act, exp;
    do_reset();
    @(negedge clk);
    m_tready = 1'b1; s0_tvalid = 1'b1; s0_tdata = 32'h0000_00AA; s0_tkeep = 4'hF; s0_tlast = 1'b1;
    @(negedge clk);
    @(negedge clk);
    s0_tvalid = 1'b0;
    s1_tvalid = 1'b1; s1_tdata = 32'hC1000000; s1_tkeep = 4'hF; s1_tlast = 1'b0;
    #1;
`ifdef USB_TX_ARB_STATS_EN
    n_cmp++;
    if (pkt_cnt0 !== 16'd1) begin
      n_err++; $display("FAIL mid_pre_stats: got %0d want 1", pkt_cnt0);
    end
`endif
    @(negedge clk);
    @(negedge clk);
    s1_tdata = 32'hC1000001;
    #1;
    n_cmp++;
    if ({grant, m_tvalid, m_tdata} !== {2'b10, 1'b1, 32'hC1000001}) begin
      n_err++; $display("FAIL mid_pre_grant: got %h want %h", {grant, m_tvalid, m_tdata},
                        {2'b10, 1'b1, 32'hC1000001});
    end
    #2;
    rstn = 1'b0;
    #1;
    act = {m_tvalid, m_tdata, m_tkeep, m_tlast, s0_tready, s1_tready, grant, busy};
    n_cmp++;
    if (act !== 43'd0) begin
      n_err++; $display("FAIL mid_async_reset: got %h want 0", act);
    end
`ifdef USB_TX_ARB_STATS_EN
    n_cmp++;
    if ({pkt_cnt0, pkt_cnt1, stall_cnt} !== 48'd0) begin
      n_err++; $display("FAIL mid_reset_stats: got %h want 0", {pkt_cnt0, pkt_cnt1, stall_cnt});
    end
`endif
    @(negedge clk);
    s1_tvalid = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    s0_tvalid = 1'b1; s0_tdata = 32'h600D0001; s0_tkeep = 4'hF; s0_tlast = 1'b1;
    #1;
    n_cmp++;
    if ({grant, m_tvalid} !== 3'b000) begin
      n_err++; $display("FAIL mid_post_idle: got grant=%b m_tvalid=%b want 00/0", grant, m_tvalid);
    end
    @(negedge clk); #1;
    act = {m_tvalid, m_tdata, m_tkeep, m_tlast, s0_tready, s1_tready, grant, busy};
    exp = {1'b1, 32'h600D0001, 4'hF, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1};
    n_cmp++;
    if (act !== exp) begin
      n_err++; $display("FAIL mid_post_grant: got %h want %h", act, exp);
    end
    @(negedge clk);
    s0_tvalid = 1'b0;
    #1;
    n_cmp++;
    if ({grant, busy} !== 3'b000) begin
      n_err++; $display("FAIL mid_post_done: got grant=%b busy=%b want 00/0", grant, busy);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time %0t reached, want finish earlier", $time);
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    idle_inputs();
    test_reset();
    test_s0_basic();
    test_zero_len();
    test_round_robin();
    test_stalls();
    test_fixed_prio();
    test_random(3000);
`ifdef USB_TX_ARB_STATS_EN
    test_stats_clr();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
